// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one SRAM-like memory port between the instruction-fetch bus (ibus)
//   and the data bus (dbus). Each access goes through a req/addr_ok/data_ok
//   handshake, one at a time, data first. A single combinational stall holds
//   the pipeline until every access requested in the current step is done.
// Ports:
//   i_clk, i_resetn          clock, async active-low reset
//   i_ibus_*, o_ibus_rdata   fetch request / registered fetched word
//   i_dbus_*, o_dbus_rdata   data request / registered load data
//   o_stall                  global pipeline hold
//   o_mem_*                  request side of the memory port
//   i_mem_*                  accept, response and read data from memory
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  input  logic                i_ibus_en,
  input  logic [ADDR_W-1:0]   i_ibus_addr,
  output logic [DATA_W-1:0]   o_ibus_rdata,
  input  logic                i_dbus_en,
  input  logic [DATA_W/8-1:0] i_dbus_we,
  input  logic [ADDR_W-1:0]   i_dbus_addr,
  input  logic [DATA_W-1:0]   i_dbus_wdata,
  output logic [DATA_W-1:0]   o_dbus_rdata,
  output logic                o_stall,
  output logic                o_mem_req,
  output logic                o_mem_wr,
  output logic [DATA_W/8-1:0] o_mem_wstrb,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_addr_ok,
  input  logic                i_mem_data_ok,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_D_REQ, S_D_WAIT, S_I_REQ, S_I_WAIT} state_t;

  state_t r_state, w_state_nxt;
  logic   r_i_done, r_d_done;
  logic   r_mem_req;
  logic   w_i_pend, w_d_pend;
  logic   w_i_fin, w_d_fin;
  logic   w_d_sel;

  // A bus is pending while it asks and has not completed in this step.
  assign w_i_pend = i_ibus_en & ~r_i_done;
  assign w_d_pend = i_dbus_en & ~r_d_done;
  assign o_stall  = w_i_pend | w_d_pend;

  always_comb begin
    w_state_nxt = r_state;
    w_i_fin     = 1'b0;
    w_d_fin     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_d_pend)      w_state_nxt = S_D_REQ;
        else if (w_i_pend) w_state_nxt = S_I_REQ;
      end
      S_D_REQ: begin
        // addr_ok and data_ok together: finish the access right here
        if (i_mem_addr_ok) begin
          if (i_mem_data_ok) begin
            w_d_fin     = 1'b1;
            w_state_nxt = w_i_pend ? S_I_REQ : S_IDLE;
          end else begin
            w_state_nxt = S_D_WAIT;
          end
        end
      end
      S_D_WAIT: begin
        if (i_mem_data_ok) begin
          w_d_fin     = 1'b1;
          w_state_nxt = w_i_pend ? S_I_REQ : S_IDLE;
        end
      end
      S_I_REQ: begin
        if (i_mem_addr_ok) begin
          if (i_mem_data_ok) begin
            w_i_fin     = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_I_WAIT;
          end
        end
      end
      S_I_WAIT: begin
        if (i_mem_data_ok) begin
          w_i_fin     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state      <= S_IDLE;
      r_mem_req    <= 1'b0;
      r_i_done     <= 1'b0;
      r_d_done     <= 1'b0;
      o_ibus_rdata <= '0;
      o_dbus_rdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      // registered from next state so it is high on the first REQ cycle
      r_mem_req <= (w_state_nxt == S_D_REQ) || (w_state_nxt == S_I_REQ);
      // flags live for one pipeline step; the step ends when stall drops
      if (!o_stall) begin
        r_i_done <= 1'b0;
        r_d_done <= 1'b0;
      end else begin
        if (w_i_fin) r_i_done <= 1'b1;
        if (w_d_fin) r_d_done <= 1'b1;
      end
      if (w_i_fin)               o_ibus_rdata <= i_mem_rdata;
      if (w_d_fin && ~|i_dbus_we) o_dbus_rdata <= i_mem_rdata;
    end
  end

  // Request fields come straight from the held bus inputs, so they stay
  // stable for as long as the request is waiting for addr_ok.
  assign w_d_sel     = (r_state == S_D_REQ);
  assign o_mem_req   = r_mem_req;
  assign o_mem_wr    = w_d_sel & (|i_dbus_we);
  assign o_mem_wstrb = w_d_sel ? i_dbus_we : '0;
  assign o_mem_addr  = w_d_sel ? i_dbus_addr : i_ibus_addr;
  assign o_mem_wdata = i_dbus_wdata;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch bus (ibus) and the data bus (dbus) driven by the MM-stage memory controller.
- Sequences each access through a request/addr_ok/data_ok handshake, gives data priority, and holds the pipeline with one global stall until every access pending in the current cycle has completed.
- Sits between the core datapath and the external memory/cache interface.

Parameters:
- ADDR_W, 32, address width of ibus, dbus and memory port.
- DATA_W, 32, data width; byte-strobe width is DATA_W/8.

Ports:
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- ibus_en  in  1  fetch request valid, held stable while stall=1
- ibus_addr  in  ADDR_W  fetch address
- ibus_rdata  out  DATA_W  fetched instruction, registered
- dbus_en  in  1  data access valid, held stable while stall=1
- dbus_we  in  DATA_W/8  byte write enables; 0 means read
- dbus_addr  in  ADDR_W  data address
- dbus_wdata  in  DATA_W  store data
- dbus_rdata  out  DATA_W  load data, registered
- stall  out  1  global pipeline hold, combinational
- mem_req  out  1  memory request valid
- mem_wr  out  1  1 = write
- mem_wstrb  out  DATA_W/8  byte strobes, equal to dbus_we on data writes, 0 otherwise
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_addr_ok  in  1  request accepted this cycle
- mem_data_ok  in  1  response/write ack this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_data_ok

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; i_done=0, d_done=0.
  - ibus_rdata=0, dbus_rdata=0, mem_req=0; stall follows its equation.
- States:
  - IDLE: no access outstanding. If dbus_en & ~d_done, go D_REQ; else if ibus_en & ~i_done, go I_REQ; else stay.
  - D_REQ: mem_req=1, mem_wr=|dbus_we, mem_addr=dbus_addr, mem_wdata=dbus_wdata, mem_wstrb=dbus_we. On mem_addr_ok, go D_WAIT.
  - D_WAIT: mem_req=0. On mem_data_ok, set d_done; if read, latch dbus_rdata<=mem_rdata. Then go I_REQ if ibus_en & ~i_done, else IDLE.
  - I_REQ: mem_req=1, mem_wr=0, mem_wstrb=0, mem_addr=ibus_addr. On mem_addr_ok, go I_WAIT.
  - I_WAIT: on mem_data_ok, latch ibus_rdata<=mem_rdata, set i_done, go IDLE.
- Handshake rules:
  - mem_req is registered and asserted from the cycle the state enters *_REQ.
  - Once raised, mem_req and its address, data and strobes stay stable until mem_addr_ok.
  - mem_addr_ok and mem_data_ok may arrive in the same cycle as each other. In that case, finish the WAIT actions in that same cycle.
  - Only one transaction is outstanding at a time.
- Stall equation:
  - stall = (ibus_en & ~i_done) | (dbus_en & ~d_done).
  - A completion does not clear stall until the next cycle, after the done flag is registered.
- Done flags:
  - Both flags clear at any edge where stall=0, which is when the pipeline advances.
  - An access therefore issues exactly once per pipeline step, even though en stays asserted while the pipeline is held.
- Data priority: when both buses request in the same cycle, data is served first, then fetch.
- Unused paths: if en is 0, that bus never issues a request and its rdata register holds its value.
- dbus_rdata is not updated on writes.
- Mid-transaction reset: abandons the transaction, returns to IDLE, and clears both flags. Late mem_data_ok pulses are ignored while in IDLE.
- Stray pulses: mem_addr_ok or mem_data_ok outside the matching state is ignored.

Test Plan:
- Reset sequencing: resetn=0 during D_WAIT, then release with ibus_en=1 -> state IDLE, mem_req=0 during reset, fresh fetch issued afterwards, and a stale data_ok that arrives in IDLE causes no rdata change.
- Fetch only: ibus_en=1, addr=0xBFC00000; memory returns addr_ok after 1 cycle and data_ok with 0x24080001 after 2 cycles -> stall high 4 cycles, ibus_rdata=0x24080001, one mem_req only.
- Simultaneous access: ibus addr 0x100 plus load at dbus addr 0x2000 -> data request issued first, then fetch; dbus_rdata and ibus_rdata are correct; stall drops the cycle after the fetch data_ok.
- Byte store: dbus_we=4'b0001, addr 0x3003, wdata 0xAB -> mem_wr=1, mem_wstrb=0001, dbus_rdata unchanged.
- Same-cycle accept and response: addr_ok and data_ok both asserted in the first D_REQ cycle -> access completes in that cycle, no double issue.
- Back-to-back steps: two consecutive loads with stall dropping in between -> two distinct mem requests; held en does not re-issue while stalled.
